// File: rtl/chipper_inject_queue.sv
// Local injection stage for the Chipper deflection router. It ejects one flit
// addressed to this node and injects the local FIFO head into a free link slot.
module chipper_inject_queue #(
  parameter int              ADDR_W     = 5,
  parameter int              DEPTH      = 4,
  parameter logic [ADDR_W-1:0] LOCAL_ID = 5'b00100,
  parameter int              STARVE_LIM = 8,
  localparam int             FLIT_W     = ADDR_W + 1,
  localparam int             CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_e,
  input  logic [FLIT_W-1:0] in_w,
  input  logic [FLIT_W-1:0] in_n,
  input  logic [FLIT_W-1:0] in_s,
  input  logic [ADDR_W-1:0] local_in,
  input  logic              local_valid,
  output logic              local_ready,
  output logic [FLIT_W-1:0] out_e,
  output logic [FLIT_W-1:0] out_w,
  output logic [FLIT_W-1:0] out_n,
  output logic [FLIT_W-1:0] out_s,
  output logic [FLIT_W-1:0] eject_flit,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              starve
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SC_W  = $clog2(STARVE_LIM + 1);

  logic [FLIT_W-1:0] in_slot [4];
  logic [FLIT_W-1:0] post_slot [4];
  logic [FLIT_W-1:0] next_slot [4];
  logic [FLIT_W-1:0] out_reg [4];
  logic [FLIT_W-1:0] eject_next, eject_reg;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [SC_W-1:0]   starve_cnt_reg, starve_cnt_next;
  logic              starve_reg;

  logic fifo_empty, push, pop;

  assign in_slot[0] = in_e;
  assign in_slot[1] = in_w;
  assign in_slot[2] = in_n;
  assign in_slot[3] = in_s;

  assign fifo_empty  = (count_reg == '0);
  assign local_ready = (count_reg != CNT_W'(DEPTH));
  assign push        = local_valid && local_ready;

  // Eject the lowest-index local flit, then inject into the lowest free slot.
  always_comb begin
    logic ejected;
    logic injected;
    ejected    = 1'b0;
    injected   = 1'b0;
    eject_next = '0;
    for (int i = 0; i < 4; i++) begin
      post_slot[i] = in_slot[i];
      if (!ejected && in_slot[i][FLIT_W-1] && (in_slot[i][ADDR_W-1:0] == LOCAL_ID)) begin
        ejected      = 1'b1;
        eject_next   = in_slot[i];
        post_slot[i] = '0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      next_slot[i] = post_slot[i];
      if (!injected && !fifo_empty && !post_slot[i][FLIT_W-1]) begin
        injected     = 1'b1;
        next_slot[i] = {1'b1, mem[rd_ptr_reg]};
      end
    end
    pop = injected;
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (fifo_empty || pop)
      starve_cnt_next = '0;
    else if (starve_cnt_reg < SC_W'(STARVE_LIM))
      starve_cnt_next = starve_cnt_reg + 1'b1;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) out_reg[gi] <= '0;
        else     out_reg[gi] <= next_slot[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eject_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      starve_cnt_reg <= '0;
      starve_reg     <= 1'b0;
    end else begin
      eject_reg      <= eject_next;
      starve_cnt_reg <= starve_cnt_next;
      starve_reg     <= (starve_cnt_next >= SC_W'(STARVE_LIM));
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= local_in;
  end

  assign out_e      = out_reg[0];
  assign out_w      = out_reg[1];
  assign out_n      = out_reg[2];
  assign out_s      = out_reg[3];
  assign eject_flit = eject_reg;
  assign fifo_count = count_reg;
  assign starve     = starve_reg;

endmodule

// File: tb/tb_chipper_inject_queue.sv
// Directed bench for chipper_inject_queue: eject priority, injection slot
// choice, FIFO backpressure, starvation and asynchronous reset.
module tb_chipper_inject_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] in_e, in_w, in_n, in_s;
  logic [4:0] local_in;
  logic       local_valid;
  logic       local_ready;
  logic [5:0] out_e, out_w, out_n, out_s, eject_flit;
  logic [2:0] fifo_count;
  logic       starve;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [5:0] BLK = 6'b100001;  // valid, non-local

  chipper_inject_queue dut (
    .clk(clk), .rst(rst),
    .in_e(in_e), .in_w(in_w), .in_n(in_n), .in_s(in_s),
    .local_in(local_in), .local_valid(local_valid), .local_ready(local_ready),
    .out_e(out_e), .out_w(out_w), .out_n(out_n), .out_s(out_s),
    .eject_flit(eject_flit), .fifo_count(fifo_count), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slots(input logic [5:0] e, input logic [5:0] w,
                       input logic [5:0] n, input logic [5:0] s);
    in_e = e; in_w = w; in_n = n; in_s = s;
  endtask

  task automatic test_reset();
    rst = 1'b1; local_valid = 1'b0; local_in = '0;
    slots(6'd0, 6'd0, 6'd0, 6'd0);
    step(); step();
    n_cmp++; if ({out_e, out_w, out_n, out_s} !== 24'd0) begin n_bad++; $display("FAIL reset_out got %h exp 0", {out_e, out_w, out_n, out_s}); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    n_cmp++; if (local_ready !== 1'b1 || starve !== 1'b0) begin n_bad++; $display("FAIL reset_flags got ready=%b starve=%b exp 1/0", local_ready, starve); end
    rst = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_eject_priority();
    slots(6'b100100, 6'd0, 6'b100100, 6'd0);
    step();
    n_cmp++; if (eject_flit !== 6'b100100) begin n_bad++; $display("FAIL eject_flit got %b exp 100100", eject_flit); end
    n_cmp++; if (out_e !== 6'd0) begin n_bad++; $display("FAIL eject_out_e got %b exp 000000", out_e); end
    n_cmp++; if (out_n !== 6'b100100) begin n_bad++; $display("FAIL eject_out_n got %b exp 100100", out_n); end
    n_cmp++; if (out_w !== 6'd0 || out_s !== 6'd0) begin n_bad++; $display("FAIL eject_out_ws got %b/%b exp 0/0", out_w, out_s); end
    $display("test_eject_priority done");
  endtask

  task automatic test_inject_freed();
    slots(BLK, BLK, BLK, BLK);
    local_in = 5'b01111; local_valid = 1'b1;
    step();
    local_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL freed_push_count got %0d exp 1", fifo_count); end
    n_cmp++; if (out_w !== BLK || eject_flit !== 6'd0) begin n_bad++; $display("FAIL freed_blocked got w=%b ej=%b exp 100001/0", out_w, eject_flit); end
    slots(BLK, 6'b100100, BLK, BLK);
    step();
    n_cmp++; if (out_w !== 6'b101111) begin n_bad++; $display("FAIL freed_out_w got %b exp 101111", out_w); end
    n_cmp++; if (eject_flit !== 6'b100100) begin n_bad++; $display("FAIL freed_eject got %b exp 100100", eject_flit); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL freed_count got %0d exp 0", fifo_count); end
    $display("test_inject_freed done");
  endtask

  task automatic test_lowest_free();
    slots(BLK, BLK, BLK, BLK);
    local_in = 5'b00011; local_valid = 1'b1;
    step();
    local_valid = 1'b0;
    slots(6'b100001, 6'd0, 6'b100010, 6'd0);
    step();
    n_cmp++; if (out_w !== 6'b100011) begin n_bad++; $display("FAIL lowest_out_w got %b exp 100011", out_w); end
    n_cmp++; if (out_e !== 6'b100001) begin n_bad++; $display("FAIL lowest_out_e got %b exp 100001", out_e); end
    n_cmp++; if (out_n !== 6'b100010 || out_s !== 6'd0) begin n_bad++; $display("FAIL lowest_out_ns got %b/%b exp 100010/0", out_n, out_s); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL lowest_count got %0d exp 0", fifo_count); end
    $display("test_lowest_free done");
  endtask

  task automatic test_no_bypass();
    slots(6'd0, 6'd0, 6'd0, 6'd0);
    local_in = 5'b01000; local_valid = 1'b1;
    step();
    local_valid = 1'b0;
    n_cmp++; if (out_e !== 6'd0 || fifo_count !== 3'd1) begin n_bad++; $display("FAIL bypass_first got e=%b cnt=%0d exp 0/1", out_e, fifo_count); end
    step();
    n_cmp++; if (out_e !== 6'b101000 || fifo_count !== 3'd0) begin n_bad++; $display("FAIL bypass_second got e=%b cnt=%0d exp 101000/0", out_e, fifo_count); end
    $display("test_no_bypass done");
  endtask

  task automatic test_full();
    logic [4:0] v;
    slots(BLK, BLK, BLK, BLK);
    local_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = 5'd10 + 5'(i);
      local_in = v;
      step();
      n_cmp++; if (fifo_count !== 3'(i + 1)) begin n_bad++; $display("FAIL full_count%0d got %0d exp %0d", i, fifo_count, i + 1); end
    end
    n_cmp++; if (local_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b exp 0", local_ready); end
    local_in = 5'b11111;
    step();
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_fifth_push got %0d exp 4", fifo_count); end
    slots(6'd0, BLK, BLK, BLK);
    step();
    local_valid = 1'b0;
    n_cmp++; if (out_e !== 6'b101010) begin n_bad++; $display("FAIL full_pop_head got %b exp 101010", out_e); end
    n_cmp++; if (fifo_count !== 3'd3 || local_ready !== 1'b1) begin n_bad++; $display("FAIL full_after_pop got cnt=%0d ready=%b exp 3/1", fifo_count, local_ready); end
    slots(BLK, BLK, BLK, BLK);
    $display("test_full done");
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (fifo_count !== 3'd0 || local_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_fifo got cnt=%0d ready=%b exp 0/1", fifo_count, local_ready); end
    n_cmp++; if ({out_e, out_w, out_n, out_s, eject_flit} !== 30'd0 || starve !== 1'b0) begin n_bad++; $display("FAIL midreset_out got %h starve=%b exp 0/0", {out_e, out_w, out_n, out_s, eject_flit}, starve); end
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (fifo_count !== 3'd0 || out_e !== BLK) begin n_bad++; $display("FAIL midreset_after got cnt=%0d e=%b exp 0/100001", fifo_count, out_e); end
    $display("test_reset_mid done");
  endtask

  task automatic test_starvation();
    slots(BLK, BLK, BLK, BLK);
    local_in = 5'b00111; local_valid = 1'b1;
    step();
    local_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_cmp++; if (starve !== (i == 8)) begin n_bad++; $display("FAIL starve_edge%0d got %b exp %b", i, starve, (i == 8)); end
    end
    step();
    n_cmp++; if (starve !== 1'b1) begin n_bad++; $display("FAIL starve_saturate got %b exp 1", starve); end
    slots(BLK, BLK, BLK, 6'd0);
    step();
    n_cmp++; if (out_s !== 6'b100111 || starve !== 1'b0) begin n_bad++; $display("FAIL starve_release got s=%b starve=%b exp 100111/0", out_s, starve); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL starve_count got %0d exp 0", fifo_count); end
    $display("test_starvation done");
  endtask

  initial begin
    test_reset();
    test_eject_priority();
    test_inject_freed();
    test_lowest_free();
    test_no_bypass();
    test_full();
    test_reset_mid();
    test_starvation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chipper_inject_queue.md
# chipper_inject_queue

Parametrised local-injection stage for the Chipper bufferless deflection router. It sits between the four incoming link registers (east, west, north, south) and the permutation/routing stage. Each cycle it ejects at most one flit addressed to this node and injects the head of a local FIFO into a free link slot. A starvation flag is raised when local traffic cannot inject.

## Interface
- ADDR_W, 5, destination address width; flit width FLIT_W = ADDR_W+1
- DEPTH, 4, local injection FIFO depth (power of two, >= 2)
- LOCAL_ID, 5'b00100, this node's address
- STARVE_LIM, 8, consecutive blocked cycles before `starve` asserts (>= 1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_e / in_w / in_n / in_s  in  FLIT_W  incoming link flits; slot index 0=east, 1=west, 2=north, 3=south; bit FLIT_W-1 = valid, [ADDR_W-1:0] = destination
- local_in  in  ADDR_W  local flit destination to enqueue
- local_valid  in  1  local enqueue request
- local_ready  out  1  FIFO not full
- out_e / out_w / out_n / out_s  out  FLIT_W  registered flits to routing stage, same slot order and format
- eject_flit  out  FLIT_W  registered ejected flit (valid bit set when ejecting)
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
- starve  out  1  registered starvation flag

## Operation
- Enqueue: push `local_in` when local_valid && local_ready. `local_ready = (fifo_count != DEPTH)`, combinational from count only; no push while full, even if a pop occurs the same cycle.
- Eject: among valid slots whose destination == LOCAL_ID, the lowest index (E>W>N>S) is ejected. That slot becomes free (output valid=0); eject_flit = that flit. Further matching flits pass through unchanged.
- Inject: if the FIFO is non-empty, the head is placed into the lowest-index slot that is free after ejection (original valid=0 or just ejected), with valid=1; FIFO pops. One injection per cycle at most.
- Non-ejected, non-free slots pass straight through.
- Starvation counter: increments (saturating at STARVE_LIM) each cycle the FIFO is non-empty and no injection occurs; clears on injection or when the FIFO is empty. `starve` = counter >= STARVE_LIM.
- fifo_count: +1 on push, -1 on pop, unchanged on both or neither.

## Timing
- All outputs are registered: slot inputs sampled at edge k appear on out_*/eject_flit after edge k.
- No bypass: a flit pushed at edge k is first eligible to inject in the cycle after edge k (appears on out_* after edge k+1).
- Reset (asynchronous, any time, including mid-operation): out_* = 0, eject_flit = 0, FIFO emptied, fifo_count = 0, starve = 0, counter = 0. local_ready = 1 once reset is applied. Flits held in the FIFO are discarded.
- Empty FIFO: no pop, no injection, out_* equals post-ejection slots.
- Full FIFO with simultaneous inject: pop occurs, count becomes DEPTH-1, and local_ready rises in the next cycle.
- FIFO pointers wrap modulo DEPTH.
- `starve` asserts after the edge at which the counter reaches STARVE_LIM. It deasserts after the edge where injection occurs.

## Test plan
- Reset mid-traffic: fill FIFO to 3, assert rst -> out_*=0, eject_flit=0, fifo_count=0, starve=0, local_ready=1 immediately.
- Eject priority: in_e=6'b100100, in_n=6'b100100, others invalid, LOCAL_ID=5'b00100 -> eject_flit=6'b100100, out_e=0, out_n=6'b100100.
- Inject into freed slot: FIFO head 5'b01111, all four slots valid, in_w=6'b100100 -> eject in_w; out_w=6'b101111; fifo_count decrements by 1.
- Lowest free slot: FIFO head 5'b00011, in_e valid to 5'b00001, in_w invalid -> out_w=6'b100011, out_e unchanged.
- Full/backpressure: push 4 flits with no free slots -> fifo_count=4, local_ready=0; 5th push ignored; free in_e -> count=3, and local_ready=1 the following cycle.
- Starvation: FIFO non-empty, all slots valid and non-local for 8 cycles -> starve=1 after the 8th edge; then free one slot -> injection occurs, and starve=0 after that edge.
